// File: rtl/avalon_flit_bridge_mc_if.sv
// Avalon-MM bus bundle for the multi-channel flit bridge.
// The address carries {channel, reg[2:0]}, with at least one channel bit.
interface avalon_flit_bridge_mc_if #(
    parameter int NUM_CH = 2
) ();
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [CW+2:0] address;
    logic          read;
    logic          write;
    logic [31:0]   writedata;
    logic [31:0]   readdata;
    logic          irq;

    modport master (
        output address, read, write, writedata,
        input  readdata, irq
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/avalon_flit_bridge_mc.sv
// Multi-channel Avalon-MM slave bridge to the flit network.
// Each channel owns a TX FIFO feeding the put port, an RX FIFO filled from the
// get port, interrupt enables, sticky error flags and 32-bit traffic counters.
module avalon_flit_bridge_mc #(
    parameter int DATA_W   = 32,
    parameter int NUM_CH   = 2,
    parameter int TX_DEPTH = 4,
    parameter int RX_DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    avalon_flit_bridge_mc_if.slave   bus,
    output logic [NUM_CH*DATA_W-1:0] out_flit,
    output logic [NUM_CH-1:0]        out_en,
    input  logic [NUM_CH-1:0]        out_rdy,
    input  logic [NUM_CH*DATA_W-1:0] in_flit,
    input  logic [NUM_CH-1:0]        in_rdy,
    output logic [NUM_CH-1:0]        in_en
);
    localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int TPW = $clog2(TX_DEPTH);
    localparam int TCW = TPW + 1;
    localparam int RPW = $clog2(RX_DEPTH);
    localparam int RCW = RPW + 1;

    localparam logic [2:0] REG_STATUS = 3'd0;
    localparam logic [2:0] REG_TXDATA = 3'd1;
    localparam logic [2:0] REG_RXDATA = 3'd2;
    localparam logic [2:0] REG_IRQ_EN = 3'd3;
    localparam logic [2:0] REG_TXCNT  = 3'd4;
    localparam logic [2:0] REG_RXCNT  = 3'd5;

    logic [CW-1:0]        ch_sel;
    logic [2:0]           reg_sel;
    logic                 rd_only;
    logic [NUM_CH*32-1:0] rd_val_flat;
    logic [NUM_CH-1:0]    ch_irq;
    logic [31:0]          rd_mux;
    logic [31:0]          readdata_reg;
    logic                 irq_reg;

    assign ch_sel  = bus.address[CW+2:3];
    assign reg_sel = bus.address[2:0];
    // A write alongside a read wins: the read has no side effects.
    assign rd_only = bus.read && !bus.write;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              sel;
            logic              tx_wr, tx_push, tx_pop, tx_full, tx_empty;
            logic              rx_rd, rx_push, rx_pop, rx_full, rx_empty;
            logic [DATA_W-1:0] tx_mem [TX_DEPTH];
            logic [DATA_W-1:0] rx_mem [RX_DEPTH];
            logic [TPW-1:0]    tx_wr_ptr_reg, tx_rd_ptr_reg;
            logic [TCW-1:0]    tx_count_reg;
            logic [RPW-1:0]    rx_wr_ptr_reg, rx_rd_ptr_reg;
            logic [RCW-1:0]    rx_count_reg;
            logic [31:0]       tx_cnt_reg, rx_cnt_reg;
            logic [1:0]        irq_en_reg;
            logic              tx_drop_reg, rx_uf_reg;
            logic [31:0]       rd_val;

            assign sel = (ch_sel == CW'(gi));

            assign tx_full  = (tx_count_reg == TCW'(TX_DEPTH));
            assign tx_empty = (tx_count_reg == '0);
            assign rx_full  = (rx_count_reg == RCW'(RX_DEPTH));
            assign rx_empty = (rx_count_reg == '0);

            // Handshakes are judged on the count at the start of the cycle.
            assign out_en[gi] = !RST && out_rdy[gi] && !tx_empty;
            assign in_en[gi]  = !RST && in_rdy[gi] && !rx_full;

            assign tx_wr   = bus.write && sel && (reg_sel == REG_TXDATA);
            assign tx_push = tx_wr && !tx_full;
            assign tx_pop  = out_en[gi];
            assign rx_rd   = rd_only && sel && (reg_sel == REG_RXDATA);
            assign rx_push = in_en[gi];
            assign rx_pop  = rx_rd && !rx_empty;

            assign out_flit[gi*DATA_W +: DATA_W] = tx_mem[tx_rd_ptr_reg];

            // FIFO storage writes; contents need no reset since counts gate use.
            always_ff @(posedge CLK) begin
                if (tx_push)
                    tx_mem[tx_wr_ptr_reg] <= bus.writedata[DATA_W-1:0];
                if (rx_push)
                    rx_mem[rx_wr_ptr_reg] <= in_flit[gi*DATA_W +: DATA_W];
            end

            // TX pointers and occupancy; pointers wrap naturally (power-of-two depth).
            always_ff @(posedge CLK) begin
                if (RST) begin
                    tx_wr_ptr_reg <= '0;
                    tx_rd_ptr_reg <= '0;
                    tx_count_reg  <= '0;
                end else begin
                    if (tx_push)
                        tx_wr_ptr_reg <= tx_wr_ptr_reg + 1'b1;
                    if (tx_pop)
                        tx_rd_ptr_reg <= tx_rd_ptr_reg + 1'b1;
                    if (tx_push && !tx_pop)
                        tx_count_reg <= tx_count_reg + 1'b1;
                    else if (!tx_push && tx_pop)
                        tx_count_reg <= tx_count_reg - 1'b1;
                end
            end

            // RX pointers and occupancy.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    rx_wr_ptr_reg <= '0;
                    rx_rd_ptr_reg <= '0;
                    rx_count_reg  <= '0;
                end else begin
                    if (rx_push)
                        rx_wr_ptr_reg <= rx_wr_ptr_reg + 1'b1;
                    if (rx_pop)
                        rx_rd_ptr_reg <= rx_rd_ptr_reg + 1'b1;
                    if (rx_push && !rx_pop)
                        rx_count_reg <= rx_count_reg + 1'b1;
                    else if (!rx_push && rx_pop)
                        rx_count_reg <= rx_count_reg - 1'b1;
                end
            end

            // Control registers: interrupt enables, sticky flags, traffic counters.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    irq_en_reg  <= '0;
                    tx_drop_reg <= 1'b0;
                    rx_uf_reg   <= 1'b0;
                    tx_cnt_reg  <= '0;
                    rx_cnt_reg  <= '0;
                end else begin
                    if (tx_wr && tx_full)
                        tx_drop_reg <= 1'b1;
                    if (rx_rd && rx_empty)
                        rx_uf_reg <= 1'b1;
                    if (tx_pop)
                        tx_cnt_reg <= tx_cnt_reg + 32'd1;
                    if (rx_push)
                        rx_cnt_reg <= rx_cnt_reg + 32'd1;
                    if (bus.write && sel) begin
                        case (reg_sel)
                            REG_STATUS: begin
                                if (bus.writedata[2])
                                    tx_drop_reg <= 1'b0;
                                if (bus.writedata[3])
                                    rx_uf_reg <= 1'b0;
                            end
                            REG_IRQ_EN: irq_en_reg <= bus.writedata[1:0];
                            // Clearing overrides a same-cycle increment.
                            REG_TXCNT: if (bus.writedata == 32'd0) tx_cnt_reg <= '0;
                            REG_RXCNT: if (bus.writedata == 32'd0) rx_cnt_reg <= '0;
                            default: ;
                        endcase
                    end
                end
            end

            // Read value of the addressed register in this channel.
            always_comb begin
                rd_val = 32'd0;
                case (reg_sel)
                    REG_STATUS: rd_val = {8'h00, 8'(tx_count_reg), 8'(rx_count_reg),
                                          4'h0, rx_uf_reg, tx_drop_reg, !rx_empty, !tx_full};
                    REG_RXDATA: rd_val = rx_empty ? 32'd0 : 32'(rx_mem[rx_rd_ptr_reg]);
                    REG_IRQ_EN: rd_val = {30'd0, irq_en_reg};
                    REG_TXCNT:  rd_val = tx_cnt_reg;
                    REG_RXCNT:  rd_val = rx_cnt_reg;
                    default:    rd_val = 32'd0;
                endcase
            end

            assign rd_val_flat[gi*32 +: 32] = rd_val;
            assign ch_irq[gi] = (irq_en_reg[0] && !rx_empty) || (irq_en_reg[1] && tx_empty);
        end
    endgenerate

    // Channel select for read data; channel indices beyond NUM_CH read as zero.
    always_comb begin
        rd_mux = 32'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CW'(c))
                rd_mux = rd_val_flat[c*32 +: 32];
        end
    end

    // Registered read data (latency 1); holds between reads.
    always_ff @(posedge CLK) begin
        if (RST)
            readdata_reg <= 32'd0;
        else if (bus.write && bus.read)
            readdata_reg <= 32'd0;
        else if (bus.read)
            readdata_reg <= rd_mux;
    end

    // Registered interrupt output.
    always_ff @(posedge CLK) begin
        if (RST)
            irq_reg <= 1'b0;
        else
            irq_reg <= |ch_irq;
    end

    assign bus.readdata = readdata_reg;
    assign bus.irq      = irq_reg;
endmodule

// File: tb/tb_avalon_flit_bridge_mc.sv
// Self-checking bench for avalon_flit_bridge_mc: directed scenarios followed by
// random traffic, all checked against a queue-based behavioural model.
module tb_avalon_flit_bridge_mc;
    localparam int DATA_W = 32;
    localparam int NUM_CH = 2;
    localparam int TXD    = 4;
    localparam int RXD    = 4;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] out_flit;
    logic [NUM_CH-1:0]        out_en;
    logic [NUM_CH-1:0]        out_rdy;
    logic [NUM_CH*DATA_W-1:0] in_flit;
    logic [NUM_CH-1:0]        in_rdy;
    logic [NUM_CH-1:0]        in_en;

    avalon_flit_bridge_mc_if #(.NUM_CH(NUM_CH)) bus ();

    avalon_flit_bridge_mc #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
    ) dut (
        .CLK(clk), .RST(rst), .bus(bus),
        .out_flit(out_flit), .out_en(out_en), .out_rdy(out_rdy),
        .in_flit(in_flit), .in_rdy(in_rdy), .in_en(in_en)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Behavioural model state
    logic [31:0] txq [NUM_CH][$];
    logic [31:0] rxq [NUM_CH][$];
    int unsigned m_txcnt [NUM_CH];
    int unsigned m_rxcnt [NUM_CH];
    bit          m_drop  [NUM_CH];
    bit          m_uf    [NUM_CH];
    bit [1:0]    m_irqen [NUM_CH];
    logic [31:0] m_rd  = 32'd0;
    bit          m_irq = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_reg(input int ch, input int rg);
        if (ch >= NUM_CH) return 32'd0;
        case (rg)
            0: return {8'h00, 8'(txq[ch].size()), 8'(rxq[ch].size()), 4'h0,
                       m_uf[ch], m_drop[ch], rxq[ch].size() != 0, txq[ch].size() < TXD};
            2: return (rxq[ch].size() != 0) ? rxq[ch][0] : 32'd0;
            3: return {30'd0, m_irqen[ch]};
            4: return m_txcnt[ch];
            5: return m_rxcnt[ch];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            txq[c].delete();
            rxq[c].delete();
            m_txcnt[c] = 0;
            m_rxcnt[c] = 0;
            m_drop[c]  = 1'b0;
            m_uf[c]    = 1'b0;
            m_irqen[c] = 2'b00;
        end
        m_rd  = 32'd0;
        m_irq = 1'b0;
    endtask

    // One clock: check handshakes, advance the model, check registered outputs.
    task automatic cycle();
        bit eo [NUM_CH];
        bit ei [NUM_CH];
        bit irq_n;
        int ch, rg, pre_tx, pre_rx;
        #1;
        for (int c = 0; c < NUM_CH; c++) begin
            eo[c] = !rst && out_rdy[c] && (txq[c].size() != 0);
            ei[c] = !rst && in_rdy[c] && (rxq[c].size() < RXD);
            check($sformatf("out_en%0d", c), 32'(out_en[c]), 32'(eo[c]));
            check($sformatf("in_en%0d", c), 32'(in_en[c]), 32'(ei[c]));
            if (txq[c].size() != 0)
                check($sformatf("out_flit%0d", c), out_flit[c*DATA_W +: DATA_W], txq[c][0]);
        end
        if (rst) begin
            model_reset();
        end else begin
            irq_n = 1'b0;
            for (int c = 0; c < NUM_CH; c++)
                irq_n |= (m_irqen[c][0] && rxq[c].size() != 0) ||
                         (m_irqen[c][1] && txq[c].size() == 0);
            ch = int'(bus.address[3]);
            rg = int'(bus.address[2:0]);
            if (bus.read && bus.write) m_rd = 32'd0;
            else if (bus.read)         m_rd = model_reg(ch, rg);
            for (int c = 0; c < NUM_CH; c++) begin
                pre_tx = txq[c].size();
                pre_rx = rxq[c].size();
                if (eo[c]) begin
                    void'(txq[c].pop_front());
                    m_txcnt[c]++;
                end
                if (bus.write && ch == c && rg == 1) begin
                    if (pre_tx == TXD) m_drop[c] = 1'b1;
                    else txq[c].push_back(bus.writedata);
                end
                if (bus.read && !bus.write && ch == c && rg == 2) begin
                    if (pre_rx == 0) m_uf[c] = 1'b1;
                    else void'(rxq[c].pop_front());
                end
                if (ei[c]) begin
                    rxq[c].push_back(in_flit[c*DATA_W +: DATA_W]);
                    m_rxcnt[c]++;
                end
                if (bus.write && ch == c) begin
                    case (rg)
                        0: begin
                            if (bus.writedata[2]) m_drop[c] = 1'b0;
                            if (bus.writedata[3]) m_uf[c] = 1'b0;
                        end
                        3: m_irqen[c] = bus.writedata[1:0];
                        4: if (bus.writedata == 0) m_txcnt[c] = 0;
                        5: if (bus.writedata == 0) m_rxcnt[c] = 0;
                        default: ;
                    endcase
                end
            end
            m_irq = irq_n;
        end
        @(posedge clk);
        @(negedge clk);
        check("readdata", bus.readdata, m_rd);
        check("irq", 32'(bus.irq), 32'(m_irq));
    endtask

    task automatic bus_op(input bit r, input bit w, input logic [3:0] a, input logic [31:0] d);
        bus.read      = r;
        bus.write     = w;
        bus.address   = a;
        bus.writedata = d;
        cycle();
        if (r || w)
            $display("[%0t] %s ch%0d reg%0d wd=%h rd=%h", $time,
                     (r && w) ? "rd+wr" : (r ? "rd   " : "wr   "), a[3], a[2:0], d, bus.readdata);
        bus.read  = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    int          next_val;
    bit          cap;
    logic [31:0] sent [$];
    logic [3:0]  a;
    logic [31:0] d;
    int          op;

    initial begin
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.writedata = '0;
        out_rdy = '0; in_rdy = '0; in_flit = '0; rst = 1'b1;
        model_reset();
        @(negedge clk);

        // Reset
        idle(2);
        rst = 1'b0;
        idle(1);
        check("reset_irq", 32'(bus.irq), 32'd0);
        check("reset_readdata", bus.readdata, 32'd0);

        // TX single write
        out_rdy = 2'b01;
        bus_op(0, 1, 4'h1, 32'hA5A5_0001);
        #1;
        check("single_out_en", 32'(out_en[0]), 32'd1);
        check("single_out_flit", out_flit[31:0], 32'hA5A5_0001);
        idle(1);
        out_rdy = 2'b00;
        bus_op(1, 0, 4'h4, 32'd0);
        check("single_txcnt", bus.readdata, 32'd1);

        // TX overflow drop on ch1
        for (int i = 0; i < 5; i++)
            bus_op(0, 1, 4'h9, 32'hB000_0000 + i);
        bus_op(1, 0, 4'h8, 32'd0);
        check("ovf_txcount", 32'(bus.readdata[23:16]), 32'd4);
        check("ovf_drop", 32'(bus.readdata[2]), 32'd1);
        check("ovf_not_full", 32'(bus.readdata[0]), 32'd0);
        out_rdy = 2'b10;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (out_en[1]) sent.push_back(out_flit[63:32]);
            cycle();
        end
        out_rdy = 2'b00;
        check("ovf_sent_count", 32'(sent.size()), 32'd4);
        for (int i = 0; i < sent.size() && i < 4; i++)
            check($sformatf("ovf_order%0d", i), sent[i], 32'hB000_0000 + i);
        bus_op(0, 1, 4'h8, 32'h4);
        bus_op(1, 0, 4'h8, 32'd0);
        check("ovf_drop_clr", 32'(bus.readdata[2]), 32'd0);

        // RX fill and drain on ch0
        in_rdy = 2'b01;
        next_val = 1;
        for (int i = 0; i < 7; i++) begin
            in_flit[31:0] = 32'(next_val);
            #1;
            cap = in_en[0];
            cycle();
            if (cap) next_val++;
        end
        check("rx_fill_caps", 32'(next_val - 1), 32'd4);
        #1;
        check("rx_full_in_en", 32'(in_en[0]), 32'd0);
        in_rdy = 2'b00;
        for (int k = 1; k <= 4; k++) begin
            bus_op(1, 0, 4'h2, 32'd0);
            check($sformatf("rx_drain%0d", k), bus.readdata, 32'(k));
        end
        in_rdy = 2'b01;
        in_flit[31:0] = 32'd5;
        #1;
        check("rx_fifth_in_en", 32'(in_en[0]), 32'd1);
        cycle();
        in_rdy = 2'b00;
        bus_op(1, 0, 4'h2, 32'd0);
        check("rx_fifth_data", bus.readdata, 32'd5);

        // Interrupts and underflow
        bus_op(0, 1, 4'h3, 32'h1);
        in_flit[31:0] = 32'h77;
        in_rdy = 2'b01;
        cycle();
        in_rdy = 2'b00;
        check("irq_t1", 32'(bus.irq), 32'd0);
        idle(1);
        check("irq_t2", 32'(bus.irq), 32'd1);
        bus_op(1, 0, 4'h2, 32'd0);
        check("irq_rd_data", bus.readdata, 32'h77);
        check("irq_after_pop", 32'(bus.irq), 32'd1);
        idle(1);
        check("irq_fall", 32'(bus.irq), 32'd0);
        bus_op(1, 0, 4'h2, 32'd0);
        check("uf_data", bus.readdata, 32'd0);
        bus_op(1, 0, 4'h0, 32'd0);
        check("uf_flag", 32'(bus.readdata[3]), 32'd1);
        bus_op(0, 1, 4'h0, 32'h8);
        bus_op(0, 1, 4'h3, 32'h0);

        // Unmapped registers
        bus_op(1, 0, 4'h6, 32'd0);
        check("unmapped_r6", bus.readdata, 32'd0);
        bus_op(0, 1, 4'hF, 32'hFFFF_FFFF);
        bus_op(1, 0, 4'hF, 32'd0);
        check("unmapped_r7", bus.readdata, 32'd0);

        // Mid-operation reset with 3 entries in every FIFO
        for (int i = 0; i < 3; i++) begin
            bus_op(0, 1, 4'h1, 32'hC000_0000 + i);
            bus_op(0, 1, 4'h9, 32'hD000_0000 + i);
        end
        in_rdy = 2'b11;
        for (int i = 0; i < 3; i++) begin
            in_flit = {$urandom, $urandom};
            cycle();
        end
        in_rdy = 2'b00;
        bus_op(0, 1, 4'h3, 32'h1);
        idle(1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        out_rdy = 2'b11;
        #1;
        check("mrst_out_en", 32'(out_en), 32'd0);
        check("mrst_in_en", 32'(in_en), 32'd0);
        check("mrst_irq", 32'(bus.irq), 32'd0);
        out_rdy = 2'b00;
        bus_op(1, 0, 4'h0, 32'd0);
        check("mrst_status0", bus.readdata, 32'h1);
        bus_op(1, 0, 4'h8, 32'd0);
        check("mrst_status1", bus.readdata, 32'h1);
        bus_op(1, 0, 4'h4, 32'd0);
        check("mrst_txcnt", bus.readdata, 32'd0);

        // Random traffic on both channels
        for (int i = 0; i < 1200; i++) begin
            out_rdy = 2'($urandom) & 2'($urandom);
            in_rdy  = 2'($urandom);
            in_flit = {$urandom, $urandom};
            op = $urandom_range(0, 3);
            a  = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) a[2:0] = 3'($urandom_range(1, 2));
            d  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            bus_op(op[0], op[1], a, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
